// File: rtl/des_pkg.sv
// Shared types, constants and rotate helpers for the DES key schedule.
// Optional macro DES_KS_DECRYPT_EN enables the right-rotate helper.
package des_pkg;

  localparam int unsigned KsRounds = 16;

  // Per-round left-rotate amounts for encryption order.
  localparam logic [1:0] KsShift [KsRounds] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // C in [55:28], D in [27:0].
  typedef logic [55:0] cd_t;

  typedef enum logic [0:0] {StIdle, StRun} ks_state_e;

  // Rotate each 28-bit half left by 1 or 2.
  function automatic cd_t cd_rotl(cd_t cd, logic [1:0] amt);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (amt == 2'd2) begin
      c = {c[25:0], c[27:26]};
      d = {d[25:0], d[27:26]};
    end else begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {c, d};
  endfunction

`ifdef DES_KS_DECRYPT_EN
  // Rotate each 28-bit half right by 1 or 2.
  function automatic cd_t cd_rotr(cd_t cd, logic [1:0] amt);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (amt == 2'd2) begin
      c = {c[1:0], c[27:2]};
      d = {d[1:0], d[27:2]};
    end else begin
      c = {c[0], c[27:1]};
      d = {d[0], d[27:1]};
    end
    return {c, d};
  endfunction
`endif

endpackage

// File: rtl/p_box_64_56.sv
// PC-1: combinational 64->56 key permutation (FIPS bit 1 = din_i[63]).
module p_box_64_56 (
  input  logic [63:0] din_i,
  output logic [55:0] dout_o
);

  // FIPS PC-1 table: output bit j (1-based, MSB first) takes input FIPS bit Pc1Tab[j-1].
  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  for (genvar j = 0; j < 56; j++) begin : g_pc1
    assign dout_o[55-j] = din_i[64-Pc1Tab[j]];
  end

  // Parity bits (FIPS 8, 16, ..., 64) are dropped by PC-1.
  logic unused_parity;
  assign unused_parity = ^{din_i[56], din_i[48], din_i[40], din_i[32],
                           din_i[24], din_i[16], din_i[8], din_i[0]};

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key schedule: emits the 16 rotated C||D values over valid/ready.
// Optional macro DES_KS_DECRYPT_EN adds decryption (right-rotate) order.
module des_key_sched
  import des_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  output logic        rk_valid_o,
  input  logic        rk_ready_i,
  output logic [55:0] rk_o,
  output logic [3:0]  round_o,
  output logic        last_o
);

  localparam logic [3:0] LastRound = 4'(KsRounds - 1);

  ks_state_e   state_q, state_d;
  cd_t         rk_q, rk_d;
  logic [3:0]  round_q, round_d;
  logic        valid_q, valid_d;
  cd_t         pc1_out;

  p_box_64_56 u_pc1 (
    .din_i  (key_i),
    .dout_o (pc1_out)
  );

`ifdef DES_KS_DECRYPT_EN
  logic mode_q, mode_d;
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt_i;
`endif

  logic [3:0] round_nxt;
  assign round_nxt = round_q + 4'd1;

  // Next-state: key acceptance in idle, one rotation step per handshake in run.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    valid_d = valid_q;
`ifdef DES_KS_DECRYPT_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      StIdle: begin
        if (key_valid_i) begin
`ifdef DES_KS_DECRYPT_EN
          rk_d   = decrypt_i ? pc1_out : cd_rotl(pc1_out, KsShift[0]);
          mode_d = decrypt_i;
`else
          rk_d   = cd_rotl(pc1_out, KsShift[0]);
`endif
          round_d = 4'd0;
          valid_d = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (valid_q && rk_ready_i) begin
          if (round_q == LastRound) begin
            // rk_q and round_q intentionally hold their final values.
            valid_d = 1'b0;
            state_d = StIdle;
          end else begin
            round_d = round_nxt;
`ifdef DES_KS_DECRYPT_EN
            // Decrypt walks the table backwards: SHIFT[16-n] == KsShift[15-round_q].
            rk_d = mode_q ? cd_rotr(rk_q, KsShift[LastRound - round_q])
                          : cd_rotl(rk_q, KsShift[round_nxt]);
`else
            rk_d = cd_rotl(rk_q, KsShift[round_nxt]);
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rk_q    <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
`ifdef DES_KS_DECRYPT_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      valid_q <= valid_d;
`ifdef DES_KS_DECRYPT_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    key_ready_o = (state_q == StIdle);
    rk_valid_o  = valid_q;
    rk_o        = rk_q;
    round_o     = round_q;
    last_o      = valid_q && (round_q == LastRound);
  end

endmodule

// File: tb/tb_des_key_sched.sv
// Randomized self-checking bench for des_key_sched against a shift-sum model.
module tb_des_key_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        key_valid_i;
  logic        key_ready_o;
  logic [63:0] key_i;
  logic        decrypt_i;
  logic        rk_valid_o;
  logic        rk_ready_i;
  logic [55:0] rk_o;
  logic [3:0]  round_o;
  logic        last_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [55:0] got_rk [16];

  localparam logic [63:0] KatKey = 64'h133457799BBCDFF1;
  localparam logic [55:0] KatE0  = 56'hE19955FAACCF1E;
  localparam logic [55:0] KatE15 = 56'hF0CCAAF556678F;
  localparam logic [55:0] KatD1  = 56'hF866557AAB33C7;

  localparam int Pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int Shift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_sched dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .key_i       (key_i),
    .decrypt_i   (decrypt_i),
    .rk_valid_o  (rk_valid_o),
    .rk_ready_i  (rk_ready_i),
    .rk_o        (rk_o),
    .round_o     (round_o),
    .last_o      (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected round value: PC-1, then each half rotated by the cumulative shift.
  function automatic logic [55:0] model_rk(input logic [63:0] key, input logic dec, input int idx);
    logic [55:0] p;
    longint unsigned c, d;
    int s;
    logic eff_dec;
`ifdef DES_KS_DECRYPT_EN
    eff_dec = dec;
`else
    eff_dec = 1'b0;
`endif
    for (int j = 0; j < 56; j++) p[55-j] = key[64-Pc1[j]];
    c = longint'(p[55:28]);
    d = longint'(p[27:0]);
    s = 0;
    if (!eff_dec) begin
      for (int k = 0; k <= idx; k++) s += Shift[k];
    end else begin
      for (int k = 1; k <= idx; k++) s += Shift[16-k];
      s = 28 - (s % 28); // right rotate as equivalent left rotate
    end
    s = s % 28;
    c = ((c << s) | (c >> (28 - s))) & 64'hFFFFFFF;
    d = ((d << s) | (d >> (28 - s))) & 64'hFFFFFFF;
    return {c[27:0], d[27:0]};
  endfunction

  // Present one key and consume all 16 values, optionally with backpressure and junk keys.
  task automatic run_key(input logic [63:0] k, input logic d, input bit bp, input bit inject,
                         input bit timing);
    int idx, cycles;
    bit stalled, rdy;
    logic [55:0] prev_rk;
    logic [3:0] prev_round;
    @(negedge clk_i);
    key_i = k;
    decrypt_i = d;
    key_valid_i = 1'b1;
    check("accept_ready", key_ready_o, 1);
    @(posedge clk_i);
    #1;
    key_valid_i = 1'b0;
    key_i = {$urandom, $urandom};
    decrypt_i = ~d;
    check("busy_ready", key_ready_o, 0);
    idx = 0;
    cycles = 1;
    stalled = 0;
    prev_rk = '0;
    prev_round = '0;
    while (idx < 16 && cycles < 300) begin
      if (stalled) begin
        check("stall_rk", rk_o, prev_rk);
        check("stall_round", round_o, prev_round);
        check("stall_valid", rk_valid_o, 1);
      end else begin
        check("rk_valid", rk_valid_o, 1);
        check("round", round_o, idx);
        check("rk", rk_o, model_rk(k, d, idx));
        check("last", last_o, idx == 15);
        got_rk[idx] = rk_o;
      end
      rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      rk_ready_i = rdy;
      if (inject && $urandom_range(0, 3) == 0) begin
        key_valid_i = 1'b1;
        key_i = {$urandom, $urandom};
        decrypt_i = $urandom_range(0, 1) == 1;
      end else begin
        key_valid_i = 1'b0;
      end
      prev_rk = rk_o;
      prev_round = round_o;
      stalled = !rdy;
      if (rdy) idx++;
      @(posedge clk_i);
      #1;
      cycles++;
    end
    key_valid_i = 1'b0;
    rk_ready_i = 1'b0;
    check("timeout", 64'(idx), 16);
    check("done_ready", key_ready_o, 1);
    check("done_valid", rk_valid_o, 0);
    check("done_last", last_o, 0);
    check("hold_rk", rk_o, model_rk(k, d, 15));
    check("hold_round", round_o, 15);
    if (timing) check("ready_latency", 64'(cycles), 17);
  endtask

  // Start a key, reset while index 7 is presented, confirm the abort.
  task automatic run_abort(input logic [63:0] k);
    @(negedge clk_i);
    key_i = k;
    decrypt_i = 1'b0;
    key_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    key_valid_i = 1'b0;
    rk_ready_i = 1'b1;
    repeat (7) @(posedge clk_i);
    #1;
    check("abort_round", round_o, 7);
    check("abort_rk", rk_o, model_rk(k, 1'b0, 7));
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("abort_valid", rk_valid_o, 0);
    check("abort_rk0", rk_o, 0);
    check("abort_round0", round_o, 0);
    check("abort_kready", key_ready_o, 1);
    check("abort_last", last_o, 0);
    repeat (3) begin
      @(posedge clk_i);
      #1;
      check("abort_quiet", rk_valid_o, 0);
    end
    rk_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    key_valid_i = 1'b0;
    key_i = '0;
    decrypt_i = 1'b0;
    rk_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", rk_valid_o, 0);
    check("rst_kready", key_ready_o, 1);
    check("rst_rk", rk_o, 0);
    check("rst_round", round_o, 0);
    check("rst_last", last_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Known-answer encrypt run.
    run_key(KatKey, 1'b0, 1'b0, 1'b0, 1'b1);
    check("kat_e0", got_rk[0], KatE0);
    check("kat_e15", got_rk[15], KatE15);

    // Known-answer decrypt run (encrypt order when decryption is not built).
    run_key(KatKey, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef DES_KS_DECRYPT_EN
    check("kat_d0", got_rk[0], KatE15);
    check("kat_d1", got_rk[1], KatD1);
    check("kat_d15", got_rk[15], KatE0);
`else
    check("kat_noenc0", got_rk[0], KatE0);
    check("kat_noenc15", got_rk[15], KatE15);
`endif

    // Backpressure with spurious key pulses during RUN.
    run_key(KatKey, 1'b0, 1'b1, 1'b1, 1'b0);
    check("bp_e0", got_rk[0], KatE0);
    check("bp_e15", got_rk[15], KatE15);

    // Mid-key reset then a clean restart.
    run_abort({$urandom, $urandom});
    run_key(KatKey, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back keys, second in decrypt mode.
    run_key({$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 1'b1);
    run_key({$urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b1);

    // Random keys, modes and backpressure.
    for (int i = 0; i < 8; i++) begin
      run_key({$urandom, $urandom}, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/des_key_sched.md
# des_key_sched

- Sequential DES key-schedule generator.
- Accepts one 64-bit key and applies PC-1 to form C0‖D0.
- Emits the sixteen 56-bit rotated C‖D round values in order over a valid/ready stream.
- Sits directly upstream of the 56→48 PC-2 permutation, which consumes `rk_o` to produce the per-round subkeys for the round datapath.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- `clk_i` in 1: single clock. Everything is on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `key_valid_i` in 1: `key_i` and `decrypt_i` are valid.
- `key_ready_o` out 1: block is idle and can accept a key.
- `key_i` in 64: DES key. Bit 63 is FIPS bit 1. Parity bits are ignored by PC-1.
- `decrypt_i` in 1: 1 selects decryption order. Sampled only at key acceptance.
- `rk_valid_o` out 1: `rk_o` holds a valid round value.
- `rk_ready_i` in 1: downstream accepts `rk_o`.
- `rk_o` out 56: C in [55:28], D in [27:0], FIPS bit order MSB first.
- `round_o` out 4: generation index 0..15 of the current `rk_o`.
- `last_o` out 1: `rk_valid_o && round_o == 15`.

## Operation
- States: IDLE, RUN.
- Reset values: state IDLE, `rk_o` = 0, `round_o` = 0, `rk_valid_o` = 0, `key_ready_o` = 1, `last_o` = 0.
- `key_ready_o` = (state == IDLE). It is decoded from registered state.

IDLE:
- On `key_valid_i && key_ready_o`, compute P = PC-1(`key_i`).
- Encrypt: `rk_o` ← both 28-bit halves of P rotated left by 1.
- Decrypt: `rk_o` ← P unrotated.
- Then `round_o` ← 0, `rk_valid_o` ← 1, latch the mode, go to RUN.

RUN:
- Stall: while `rk_valid_o && !rk_ready_i`, `rk_o`, `round_o` and `rk_valid_o` hold. `key_valid_i` is ignored.
- On handshake with `round_o` < 15:
  - `round_o` ← `round_o` + 1.
  - Each half of `rk_o` is rotated by amount S(n), where n = new `round_o`.
- Encrypt: rotate left, S(n) = SHIFT[n]. Decrypt: rotate right, S(n) = SHIFT[16−n].
- Rotation table SHIFT[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- On handshake with `round_o` == 15: `rk_valid_o` ← 0, state ← IDLE. `rk_o` and `round_o` hold their last values.
- Halves rotate independently, modulo 28. Cumulative encrypt shift after index 15 is 28, so the final encrypt `rk_o` equals C0‖D0.
- Reset asserted in any state, including mid-key: abort and return to reset values on the next edge. No partial output follows.

## Timing
- Key accepted at edge N; first `rk_o` is valid in the cycle after edge N (1-cycle latency).
- With `rk_ready_i` held high, one round value is produced per cycle for 16 consecutive cycles.
- `key_ready_o` rises the cycle after the index-15 handshake. Back-to-back throughput is 17 cycles per key.
- A key cannot be accepted in the same cycle as the last handshake.
- `rk_o` changes only on an edge where a handshake (or acceptance) occurs.

## Configuration
- `DES_KS_DECRYPT_EN` defined: decryption order is supported as specified, using the right-rotate path and the SHIFT[16−n] lookup.
- Not defined: `decrypt_i` remains a port but is ignored. The block always generates encryption order, and the right-rotate logic is not built.

## Structure
- Package `des_pkg`:
  - `localparam` SHIFT table (16×2 bits).
  - typedef `cd_t` (56-bit C‖D).
  - typedef `ks_state_e` {IDLE, RUN}.
  - Round-count constant 16.
- Sub-module `p_box_64_56`: purely combinational PC-1, 64→56, FIPS table, same port style as the PC-2 block.

## Test plan
- Encrypt, key 0x133457799BBCDFF1, `rk_ready_i`=1:
  - index 0: `rk_o` = 0xE19955FAACCF1E.
  - index 15: `rk_o` = 0xF0CCAAF556678F, `last_o`=1.
  - `key_ready_o` high exactly 17 cycles after acceptance.
- Decrypt, same key:
  - index 0: 0xF0CCAAF556678F.
  - index 1: 0xF866557AAB33C7.
  - index 15: 0xE19955FAACCF1E.
- Random `rk_ready_i` backpressure: `rk_o`/`round_o` stable while stalled. All 16 values match the `rk_ready_i`=1 run. A `key_valid_i` pulse during RUN is ignored.
- `rst_i` asserted at index 7: next cycle `rk_valid_o`=0, `rk_o`=0, `key_ready_o`=1. A new key then restarts at index 0.
- Two keys back-to-back, second with `decrypt_i`=1: no overlap. The mode is sampled per key, and both sequences are correct.
- Without `DES_KS_DECRYPT_EN`: `decrypt_i`=1 produces the encrypt sequence of the first test.
